pc_flag_unit: RTL and testbench

Program-counter and condition-flag state for the single-cycle LEGv8 datapath. It consumes the execute stage's ALU flags and PC-relative branch target and keeps the architectural NZVC flag register. It evaluates branch conditions (B, B.cond, CBZ, CBNZ, BR) and advances the PC register each cycle. It also keeps a saturating count of taken branches for performance debug.

---
 rtl/pc_flag_unit.sv | 55 +++++
 tb/tb_pc_flag_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_flag_unit.sv
// pc_flag_unit: LEGv8 PC register, NZVC flags, branch resolution and saturating taken-branch counter
module pc_flag_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flags_update,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic [2:0]       br_kind,
  input  logic [3:0]       cond,
  input  logic [63:0]      cb_value,
  input  logic [63:0]      br_target,
  input  logic [63:0]      br_reg,
  output logic [63:0]      pc,
  output logic [63:0]      pc_plus4,
  output logic             taken,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] taken_count
);
  logic n, z, v, c, cond_ok;
  logic [7:0] base;
  logic [63:0] next_pc;
  assign {n, z, v, c} = flags;
  assign base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
  assign cond_ok = (cond[0] && cond != 4'hF) ? !base[cond[3:1]] : base[cond[3:1]];
  assign pc_plus4 = pc + 64'd4;
  always_comb begin
    taken = 1'b0;
    case (br_kind)
      3'd1: taken = 1'b1;
      3'd2: taken = cond_ok;
      3'd3: taken = cb_value == 64'd0;
      3'd4: taken = cb_value != 64'd0;
      3'd5: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
  assign next_pc = br_kind == 3'd5 ? br_reg : taken ? br_target : pc_plus4;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      flags <= 4'b0000;
      taken_count <= '0;
    end else if (!stall) begin
      pc <= next_pc;
      if (flags_update) flags <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
      if (taken && taken_count != '1) taken_count <= taken_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pc_flag_unit.sv
// tb_pc_flag_unit: directed self-checking bench for pc_flag_unit
module tb_pc_flag_unit;
  logic clk = 1'b0;
  logic reset, stall, flags_update, alu_n, alu_z, alu_v, alu_c;
  logic [2:0] br_kind;
  logic [3:0] cond;
  logic [63:0] cb_value, br_target, br_reg;
  logic [63:0] pc, pc_plus4, pc4, pc4_plus4;
  logic taken, taken4;
  logic [3:0] flags, flags4;
  logic [15:0] cnt;
  logic [3:0] cnt4;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  pc_flag_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flags_update(flags_update),
    .alu_negative(alu_n), .alu_zero(alu_z), .alu_overflow(alu_v), .alu_carry_out(alu_c),
    .br_kind(br_kind), .cond(cond), .cb_value(cb_value), .br_target(br_target), .br_reg(br_reg),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .flags(flags), .taken_count(cnt)
  );
  pc_flag_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flags_update(flags_update),
    .alu_negative(alu_n), .alu_zero(alu_z), .alu_overflow(alu_v), .alu_carry_out(alu_c),
    .br_kind(br_kind), .cond(cond), .cb_value(cb_value), .br_target(br_target), .br_reg(br_reg),
    .pc(pc4), .pc_plus4(pc4_plus4), .taken(taken4), .flags(flags4), .taken_count(cnt4)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    reset = 0; stall = 0; flags_update = 0;
    {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
    br_kind = 0; cond = 0; cb_value = 0; br_target = 0; br_reg = 0;
  endtask
  task automatic test_reset();
    idle();
    reset = 1; stall = 1; flags_update = 1; {alu_n, alu_z, alu_v, alu_c} = 4'b1111;
    br_kind = 5; br_reg = 64'h500;
    tick(); tick();
    n_cmp++; if (pc !== 64'd0) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 64'd0); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b exp 0000", flags); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", cnt); end
    n_cmp++; if (pc_plus4 !== 64'd4) begin n_err++; $display("FAIL reset_pc_plus4 got %h exp 4", pc_plus4); end
    n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL reset_taken_follows got %b exp 1", taken); end
    idle();
  endtask
  task automatic test_seq_fetch();
    logic [63:0] exp_pc [3] = '{64'd4, 64'd8, 64'd12};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pc !== exp_pc[i]) begin n_err++; $display("FAIL seq_pc%0d got %h exp %h", i, pc, exp_pc[i]); end
    end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL seq_count got %0d exp 0", cnt); end
  endtask
  task automatic test_bcond();
    flags_update = 1; alu_z = 1;
    tick();
    idle();
    n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL bcond_flags got %b exp 0100", flags); end
    br_kind = 2; cond = 4'h0; br_target = 64'h100;
    #1;
    n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL bcond_eq_taken got %b exp 1", taken); end
    tick();
    n_cmp++; if (pc !== 64'h100) begin n_err++; $display("FAIL bcond_eq_pc got %h exp 100", pc); end
    idle();
    flags_update = 1;
    tick();
    n_cmp++; if (pc !== 64'h104) begin n_err++; $display("FAIL bcond_clear_pc got %h exp 104", pc); end
    br_kind = 2; cond = 4'h0; br_target = 64'h200; flags_update = 1; alu_z = 1;
    #1;
    n_cmp++; if (taken !== 1'b0) begin n_err++; $display("FAIL bcond_same_cycle_taken got %b exp 0", taken); end
    tick();
    idle();
    n_cmp++; if (pc !== 64'h108) begin n_err++; $display("FAIL bcond_same_cycle_pc got %h exp 108", pc); end
    n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL bcond_same_cycle_flags got %b exp 0100", flags); end
    n_cmp++; if (cnt !== 16'd1) begin n_err++; $display("FAIL bcond_count got %0d exp 1", cnt); end
  endtask
  task automatic test_signed();
    logic [3:0] cs [6] = '{4'hB, 4'hA, 4'hC, 4'hD, 4'h1, 4'h8};
    logic exp_t [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    flags_update = 1; alu_n = 1;
    tick();
    idle();
    br_kind = 2;
    for (int i = 0; i < 6; i++) begin
      cond = cs[i];
      #1;
      n_cmp++; if (taken !== exp_t[i]) begin n_err++; $display("FAIL signed_nv10_cond%h got %b exp %b", cs[i], taken, exp_t[i]); end
    end
    br_kind = 0; flags_update = 1; alu_n = 1; alu_v = 1;
    tick();
    idle();
    br_kind = 2; cond = 4'hC;
    #1;
    n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL signed_gt_nv11 got %b exp 1", taken); end
    cond = 4'hE;
    #1;
    n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL cond_always got %b exp 1", taken); end
    br_kind = 6;
    #1;
    n_cmp++; if (taken !== 1'b0) begin n_err++; $display("FAIL kind6_taken got %b exp 0", taken); end
    idle();
  endtask
  task automatic test_cb_br();
    br_kind = 3; cb_value = 64'd5; br_target = 64'h200;
    #1;
    n_cmp++; if (taken !== 1'b0) begin n_err++; $display("FAIL cbz_nonzero_taken got %b exp 0", taken); end
    cb_value = 0;
    #1;
    n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL cbz_zero_taken got %b exp 1", taken); end
    tick();
    n_cmp++; if (pc !== 64'h200) begin n_err++; $display("FAIL cbz_pc got %h exp 200", pc); end
    br_kind = 4; cb_value = 64'd5; br_target = 64'h300;
    #1;
    n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL cbnz_taken got %b exp 1", taken); end
    tick();
    n_cmp++; if (pc !== 64'h300) begin n_err++; $display("FAIL cbnz_pc got %h exp 300", pc); end
    br_kind = 5; br_reg = 64'hDEAD_BEE0; br_target = 64'h999;
    tick();
    idle();
    n_cmp++; if (pc !== 64'hDEAD_BEE0) begin n_err++; $display("FAIL br_pc got %h exp deadbee0", pc); end
    n_cmp++; if (cnt !== 16'd4) begin n_err++; $display("FAIL cb_br_count got %0d exp 4", cnt); end
  endtask
  task automatic test_stall();
    stall = 1; br_kind = 1; br_target = 64'h400; flags_update = 1; {alu_n, alu_z, alu_v, alu_c} = 4'b0101;
    #1;
    n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL stall_taken got %b exp 1", taken); end
    n_cmp++; if (pc_plus4 !== 64'hDEAD_BEE4) begin n_err++; $display("FAIL stall_pc_plus4 got %h exp deadbee4", pc_plus4); end
    tick(); tick();
    n_cmp++; if (pc !== 64'hDEAD_BEE0) begin n_err++; $display("FAIL stall_pc got %h exp deadbee0", pc); end
    n_cmp++; if (flags !== 4'b1010) begin n_err++; $display("FAIL stall_flags got %b exp 1010", flags); end
    n_cmp++; if (cnt !== 16'd4) begin n_err++; $display("FAIL stall_count got %0d exp 4", cnt); end
    reset = 1;
    tick();
    idle();
    n_cmp++; if (pc !== 64'd0) begin n_err++; $display("FAIL reset_stall_pc got %h exp 0", pc); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_count got %0d exp 0", cnt); end
  endtask
  task automatic test_saturation();
    br_kind = 1; br_target = 64'h40;
    for (int i = 0; i < 20; i++) tick();
    idle();
    n_cmp++; if (cnt4 !== 4'hF) begin n_err++; $display("FAIL sat_count4 got %h exp f", cnt4); end
    n_cmp++; if (cnt !== 16'd20) begin n_err++; $display("FAIL sat_count16 got %0d exp 20", cnt); end
    n_cmp++; if (pc !== 64'h40) begin n_err++; $display("FAIL sat_pc got %h exp 40", pc); end
  endtask
  task automatic test_wrap();
    br_kind = 5; br_reg = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    idle();
    n_cmp++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_load_pc got %h exp fffffffffffffffc", pc); end
    n_cmp++; if (pc_plus4 !== 64'd0) begin n_err++; $display("FAIL wrap_pc_plus4_top got %h exp 0", pc_plus4); end
    tick();
    n_cmp++; if (pc !== 64'd0) begin n_err++; $display("FAIL wrap_pc got %h exp 0", pc); end
    n_cmp++; if (pc_plus4 !== 64'd4) begin n_err++; $display("FAIL wrap_pc_plus4 got %h exp 4", pc_plus4); end
  endtask
  initial begin
    idle();
    reset = 1;
    test_reset();
    test_seq_fetch();
    test_bcond();
    test_signed();
    test_cb_br();
    test_stall();
    test_saturation();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
